fp_mult_rr_sched: RTL and testbench

//   Round-robin scheduler that shares one multi-cycle FP32 multiplier unit between NREQ requesters.
//   The unit is the multiplier core plus its exception stage.

---
 rtl/fp_mult_rr_sched.sv | 129 ++++++++++++
 tb/tb_fp_mult_rr_sched.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mult_rr_sched.sv
// Round-robin front end that shares one multi-cycle FP32 multiplier between NREQ requesters,
// with a watchdog that turns a hung multiply into a flagged timeout response.
module fp_mult_rr_sched #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 64,
    localparam int IDW    = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    input  logic [NREQ*3-1:0]    req_rnd,
    output logic                 mul_start,
    output logic [31:0]          mul_a,
    output logic [31:0]          mul_b,
    output logic [2:0]           mul_rnd,
    input  logic                 mul_done,
    input  logic [31:0]          mul_z,
    input  logic [5:0]           mul_flags,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_z,
    output logic [5:0]           rsp_flags,
    output logic                 rsp_timeout
);

    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t         state;
    state_t         state_next;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] grant;
    logic           grant_found;
    logic [CW-1:0]  counter;
    logic           done_take;
    logic           timeout_hit;

    // Cyclic search for the first valid requester starting at the round-robin pointer.
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_found && req_valid[(int'(rr_ptr) + k) % NREQ]) begin
                grant_found = 1'b1;
                grant       = IDW'((int'(rr_ptr) + k) % NREQ);
            end
        end
    end

    // A done pulse coinciding with the start pulse belongs to no operation of ours.
    assign done_take   = (counter != '0) && mul_done;
    assign timeout_hit = (counter == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (grant_found) state_next = BUSY;
            BUSY: if (done_take || timeout_hit) state_next = RESP;
            RESP: if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        mul_start = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: if (grant_found) req_ready[grant] = 1'b1;
            BUSY: mul_start = (counter == '0);
            RESP: rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr      <= '0;
            counter     <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
            mul_rnd     <= '0;
            rsp_id      <= '0;
            rsp_z       <= '0;
            rsp_flags   <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        mul_a   <= req_a[32*grant +: 32];
                        mul_b   <= req_b[32*grant +: 32];
                        mul_rnd <= req_rnd[3*grant +: 3];
                        rsp_id  <= grant;
                        rr_ptr  <= (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
                        counter <= '0;
                    end
                end
                BUSY: begin
                    counter <= counter + 1'b1;
                    if (done_take) begin
                        rsp_z       <= mul_z;
                        rsp_flags   <= mul_flags;
                        rsp_timeout <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_z       <= '0;
                        rsp_flags   <= '0;
                        rsp_timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mult_rr_sched.sv
// Directed bench for fp_mult_rr_sched: a scripted multiplier responder, a transaction-level
// scheduler model checked every cycle, and literal expectations for the headline scenarios.
module tb_fp_mult_rr_sched;

    localparam int NREQ    = 2;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [5:0]  req_rnd;
    logic        mul_start;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [2:0]  mul_rnd;
    logic        mul_done;
    logic [31:0] mul_z = '0;
    logic [5:0]  mul_flags = '0;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [0:0]  rsp_id;
    logic [31:0] rsp_z;
    logic [5:0]  rsp_flags;
    logic        rsp_timeout;

    logic drv_done = 1'b0;
    logic extra_done = 1'b0;
    assign mul_done = drv_done | extra_done;

    fp_mult_rr_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_rnd(req_rnd),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_rnd(mul_rnd),
        .mul_done(mul_done), .mul_z(mul_z), .mul_flags(mul_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_z(rsp_z), .rsp_flags(rsp_flags), .rsp_timeout(rsp_timeout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    // Per-operation script in accept order: done latency k (0 = never) and the returned result.
    int          op_k[16];
    logic [31:0] op_z[16];
    logic [5:0]  op_f[16];

    // What the DUT actually did, per operation, for the literal checks.
    int          lg_gnt[16];
    int          lg_acc[16];
    int          lg_sfirst[16];
    int          lg_slen[16];
    int          lg_rfirst[16];
    int          lg_rcyc[16];
    int          lg_id[16];
    logic [31:0] lg_z[16];
    logic [5:0]  lg_f[16];
    logic        lg_to[16];

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Multiplier stand-in: answers each start pulse after the scripted number of cycles.
    int start_cnt = 0;
    int dcnt = 0;
    int cur_op = 0;

    always @(negedge clk) begin
        if (rst && mul_start) begin
            cur_op = start_cnt;
            start_cnt++;
            dcnt = op_k[cur_op];
        end
    end

    always @(posedge clk) begin
        #1;
        drv_done = 1'b0;
        if (!rst) begin
            dcnt = 0;
        end else if (dcnt > 0) begin
            dcnt--;
            if (dcnt == 0) begin
                drv_done  = 1'b1;
                mul_z     = op_z[cur_op];
                mul_flags = op_f[cur_op];
            end
        end
    end

    // Transaction-level model: either free (granting round-robin) or owning one op
    // whose start cycle, response cycle and response contents follow from the script.
    bit         m_busy = 1'b0;
    int         m_ptr = 0;
    int         m_g;
    int         m_n = 0;
    int         acc_cnt = 0;
    int         m_start = 0;
    int         m_rsp = 0;
    logic [0:0] m_id;
    logic [31:0] m_a, m_b, m_z;
    logic [2:0]  m_rnd;
    logic [5:0]  m_f;
    logic        m_to;

    always @(negedge clk) begin
        if (!rst) begin
            check_output("reset_outputs",
                {req_ready, mul_start, mul_a, mul_b, mul_rnd, rsp_valid, rsp_id, rsp_z, rsp_flags, rsp_timeout}, '0);
            m_busy = 1'b0;
            m_ptr  = 0;
        end else if (!m_busy) begin
            m_g = -1;
            for (int k = 0; k < NREQ; k++)
                if (m_g < 0 && req_valid[(m_ptr + k) % NREQ]) m_g = (m_ptr + k) % NREQ;
            check_output("req_ready_idle", req_ready, (m_g < 0) ? 0 : (1 << m_g));
            check_output("idle_quiet", {mul_start, rsp_valid}, 0);
            if (m_g >= 0) begin
                m_busy  = 1'b1;
                m_n     = acc_cnt;
                acc_cnt++;
                m_id    = 1'(m_g);
                m_a     = req_a[32*m_g +: 32];
                m_b     = req_b[32*m_g +: 32];
                m_rnd   = req_rnd[3*m_g +: 3];
                m_start = cyc + 1;
                if (op_k[m_n] > 0) begin
                    m_rsp = m_start + op_k[m_n] + 1;
                    m_z   = op_z[m_n];
                    m_f   = op_f[m_n];
                    m_to  = 1'b0;
                end else begin
                    m_rsp = m_start + TIMEOUT;
                    m_z   = '0;
                    m_f   = '0;
                    m_to  = 1'b1;
                end
                m_ptr = (m_g + 1) % NREQ;
                lg_gnt[m_n] = req_ready[1] ? 1 : (req_ready[0] ? 0 : -1);
                lg_acc[m_n] = cyc;
            end
        end else begin
            check_output("req_ready_busy", req_ready, 0);
            check_output("mul_start", mul_start, cyc == m_start);
            if (mul_start) begin
                lg_slen[m_n]++;
                if (lg_sfirst[m_n] < 0) lg_sfirst[m_n] = cyc;
            end
            if (cyc < m_rsp)
                check_output("held_operands", {mul_a, mul_b, mul_rnd}, {m_a, m_b, m_rnd});
            check_output("rsp_valid", rsp_valid, cyc >= m_rsp);
            if (cyc >= m_rsp) begin
                check_output("rsp_fields", {rsp_id, rsp_z, rsp_flags, rsp_timeout}, {m_id, m_z, m_f, m_to});
                if (rsp_valid) begin
                    lg_rcyc[m_n]++;
                    if (lg_rfirst[m_n] < 0) lg_rfirst[m_n] = cyc;
                    lg_id[m_n] = int'(rsp_id);
                    lg_z[m_n]  = rsp_z;
                    lg_f[m_n]  = rsp_flags;
                    lg_to[m_n] = rsp_timeout;
                end
                if (rsp_ready) m_busy = 1'b0;
            end
        end
    end

    task automatic wait_accept(input int id);
        bit seen = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(negedge clk);
            if (req_ready[id]) seen = 1'b1;
        end
        if (!seen) check_output("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(posedge clk);
            #1;
            if (!m_busy) done = 1'b1;
        end
        if (!done) check_output("idle_timeout", 0, 1);
    endtask

    task automatic apply_stimulus(input int id, input logic [31:0] a, input logic [31:0] b, input logic [2:0] rnd);
        @(posedge clk);
        #1;
        req_a[32*id +: 32] = a;
        req_b[32*id +: 32] = b;
        req_rnd[3*id +: 3] = rnd;
        req_valid[id]      = 1'b1;
        wait_accept(id);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int got;
        bit seen;

        for (int i = 0; i < 16; i++) begin
            op_k[i] = 1; op_z[i] = '0; op_f[i] = '0;
            lg_gnt[i] = -1; lg_acc[i] = -1; lg_sfirst[i] = -1; lg_slen[i] = 0;
            lg_rfirst[i] = -1; lg_rcyc[i] = 0; lg_id[i] = -1;
            lg_z[i] = 'x; lg_f[i] = 'x; lg_to[i] = 1'bx;
        end
        op_k[0] = 3;  op_z[0] = 32'h4040_0000; op_f[0] = 6'b000000;
        op_k[1] = 1;  op_z[1] = 32'h1111_1111; op_f[1] = 6'h01;
        op_k[2] = 2;  op_z[2] = 32'h2222_2222; op_f[2] = 6'h02;
        op_k[3] = 1;  op_z[3] = 32'h3333_3333; op_f[3] = 6'h04;
        op_k[4] = 4;  op_z[4] = 32'h4444_4444; op_f[4] = 6'h08;
        op_k[5] = 2;  op_z[5] = 32'h3F80_0000; op_f[5] = 6'h01;
        op_k[6] = 0;
        op_k[7] = 2;  op_z[7] = 32'h7F80_0000; op_f[7] = 6'b010010;
        op_k[8] = 10; op_z[8] = 32'hDEAD_BEEF; op_f[8] = 6'h3F;
        op_k[9] = 1;  op_z[9] = 32'h5555_5555; op_f[9] = 6'h01;
        op_k[10] = 1; op_z[10] = 32'h6666_6666; op_f[10] = 6'h00;
        op_k[11] = 1; op_z[11] = 32'h7777_7777; op_f[11] = 6'h00;

        req_valid = '0; req_a = '0; req_b = '0; req_rnd = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // 1.5 * 2.0 on requester 0, done after 3 cycles
        apply_stimulus(0, 32'h3FC0_0000, 32'h4000_0000, 3'd0);
        wait_idle();
        check_output("t1_id", lg_id[0], 0);
        check_output("t1_z", lg_z[0], 32'h4040_0000);
        check_output("t1_flags", lg_f[0], 6'h00);
        check_output("t1_rsp_latency", lg_rfirst[0] - lg_acc[0], 5);
        check_output("t1_start_len", lg_slen[0], 1);

        // Fresh reset so the pointer starts at 0, then both requesters hold valid
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        req_a = {32'h4100_0000, 32'h4080_0000};
        req_b = {32'h3F00_0000, 32'hBF80_0000};
        req_rnd = {3'd1, 3'd4};
        req_valid = 2'b11;
        got = 0;
        for (int c = 0; c < 400 && got < 4; c++) begin
            @(negedge clk);
            if (req_ready != 2'b00) got++;
        end
        if (got < 4) check_output("t2_accepts", got, 4);
        @(posedge clk); #1 req_valid = 2'b00;
        wait_idle();
        check_output("t2_grant0", lg_gnt[1], 0);
        check_output("t2_grant1", lg_gnt[2], 1);
        check_output("t2_grant2", lg_gnt[3], 0);
        check_output("t2_grant3", lg_gnt[4], 1);
        check_output("t2_rsp_ids", {lg_id[1], lg_id[2], lg_id[3], lg_id[4]}, {32'd0, 32'd1, 32'd0, 32'd1});

        // Back-pressured response with a stray done, requester 1 queued behind it
        rsp_ready = 1'b0;
        apply_stimulus(0, 32'h3F80_0000, 32'h3F80_0000, 3'd0);
        req_a[63:32] = 32'h4049_0FDB; req_b[63:32] = 32'h4049_0FDB; req_rnd[5:3] = 3'd2;
        req_valid[1] = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        if (!seen) check_output("t3_rsp_wait", 0, 1);
        repeat (3) @(posedge clk);
        #1 extra_done = 1'b1;
        @(posedge clk); #1 extra_done = 1'b0;
        repeat (6) @(posedge clk);
        #1 rsp_ready = 1'b1;
        wait_accept(1);
        wait_idle();
        check_output("t3_rsp_cycles", lg_rcyc[5], 11);
        check_output("t3_z", lg_z[5], 32'h3F80_0000);
        check_output("t4_grant", lg_gnt[6], 1);
        check_output("t4_timeout_delay", lg_rfirst[6] - lg_sfirst[6], 64);
        check_output("t4_timeout_fields", {lg_to[6], lg_z[6], lg_f[6]}, {1'b1, 32'h0, 6'h0});

        // Infinity result passes through untouched
        apply_stimulus(0, 32'h7F00_0000, 32'h4000_0000, 3'd0);
        wait_idle();
        check_output("t5_z", lg_z[7], 32'h7F80_0000);
        check_output("t5_flags", lg_f[7], 6'b010010);
        check_output("t5_timeout", lg_to[7], 1'b0);

        // Reset during the second BUSY cycle abandons the op
        apply_stimulus(0, 32'h4000_0000, 32'h4000_0000, 3'd0);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (mul_start) seen = 1'b1;
        end
        if (!seen) check_output("t6_start_wait", 0, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        #1 check_output("t6_reset_immediate",
            {req_ready, mul_start, mul_a, mul_b, mul_rnd, rsp_valid, rsp_id, rsp_z, rsp_flags, rsp_timeout}, '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        apply_stimulus(1, 32'h4040_0000, 32'h4040_0000, 3'd3);
        wait_idle();
        @(posedge clk);
        #1;
        req_a = {32'h4110_0000, 32'h40A0_0000};
        req_valid = 2'b11;
        wait_accept(0);
        wait_accept(1);
        wait_idle();
        check_output("t6_no_aborted_rsp", lg_rfirst[8], -1);
        check_output("t6_grant_req1", lg_gnt[9], 1);
        check_output("t6_grant_wrap", lg_gnt[10], 0);
        check_output("t6_grant_next", lg_gnt[11], 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
